// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx byte arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package uart_arb_pkg;

    // Arbiter FSM states; the prefix states only become reachable when UART_ARB_PREFIX_EN is defined
    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PREFIX_ID  = 2'd1,
        PREFIX_SEP = 2'd2,
        PASS       = 2'd3
    } arb_state_t;

    // Prefix bytes: the owner index is rendered as '0'+k, followed by ':'
    localparam logic [7:0] AsciiZero  = 8'h30;
    localparam logic [7:0] AsciiColon = 8'h3A;

    // Idle counter width. It must hold TIMEOUT_CYCLES, and it is kept 1 bit wide when the timeout is disabled.
    function automatic int cnt_width(input int timeout_cycles);
        if (timeout_cycles <= 0) begin
            return 1;
        end
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after i_ptr, wrapping to index 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when the grant is taken.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [NUM_REQ-1:0] o_gnt
);

    logic found;

    // Search the upper segment [ptr..N-1] first, then wrap around to [0..ptr-1]
    always_comb begin
        o_gnt = '0;
        found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && i_req[k] && (IDX_W'(k) >= i_ptr)) begin
                o_gnt[k] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && i_req[k]) begin
                o_gnt[k] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx byte port between NUM_REQ requesters, using a round-robin grant that stays locked until the last byte of a message.
// Latency: 1 cycle from grant to PASS; an accepted byte appears on o_tx_data on the next cycle. Throughput is 1 byte/cycle.
// Backpressure: a single registered output stage. o_req_ready is held low while that stage is full and i_tx_ready is low.
// Option: UART_ARB_PREFIX_EN inserts the bytes "<k>:" ahead of each message.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
    input  logic [NUM_REQ-1:0]            i_req_valid,
    input  logic [NUM_REQ-1:0]            i_req_last,
    output logic [NUM_REQ-1:0]            o_req_ready,
    output logic [NUM_REQ-1:0]            o_grant,
    output logic [DATA_WIDTH-1:0]         o_tx_data,
    output logic                          o_tx_valid,
    input  logic                          i_tx_ready
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
    localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
    // The counter value on the idle cycle that forces the release
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

    arb_state_t              state_q, state_d;
    logic [IDX_W-1:0]        gidx_q, gidx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        arb_idx;
    logic [IDX_W-1:0]        ptr_next;
    logic [NUM_REQ-1:0]      arb_gnt;
    logic [NUM_REQ-1:0]      grant_oh;

    logic                    tx_vld_q;
    logic [DATA_WIDTH-1:0]   tx_dat_q;
    logic                    load_en;
    logic [DATA_WIDTH-1:0]   load_dat;

    logic [DATA_WIDTH-1:0]   sel_dat;
    logic                    sel_vld;
    logic                    sel_last;
    logic                    out_free;
    logic                    req_acc;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr (
        .i_req   (i_req_valid),
        .i_ptr   (ptr_q),
        .o_gnt   (arb_gnt)
    );

    // Encode the arbiter winner as an index, and route the current owner's data/valid/last lanes
    always_comb begin
        arb_idx  = '0;
        grant_oh = '0;
        sel_dat  = '0;
        sel_vld  = 1'b0;
        sel_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                arb_idx = IDX_W'(k);
            end
            if (gidx_q == IDX_W'(k)) begin
                grant_oh[k] = 1'b1;
                sel_dat     = i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
                sel_vld     = i_req_valid[k];
                sel_last    = i_req_last[k];
            end
        end
    end

    // The output stage can take a byte when it is empty or is being drained in this cycle
    assign out_free    = !tx_vld_q || i_tx_ready;
    assign o_grant     = (state_q != IDLE) ? grant_oh : '0;
    assign o_req_ready = ((state_q == PASS) && out_free) ? grant_oh : '0;
    assign req_acc     = (state_q == PASS) && out_free && sel_vld;
    assign ptr_next    = (gidx_q == IDX_W'(NUM_REQ - 1)) ? '0 : (gidx_q + IDX_W'(1));
    assign o_tx_valid  = tx_vld_q;
    assign o_tx_data   = tx_dat_q;

    // Next state, message lock, idle timeout and output-stage load selection
    always_comb begin
        state_d  = state_q;
        gidx_d   = gidx_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        load_en  = 1'b0;
        load_dat = tx_dat_q;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                // This is an arbitration-only cycle; no byte is accepted here
                if (|i_req_valid) begin
                    gidx_d  = arb_idx;
`ifdef UART_ARB_PREFIX_EN
                    state_d = PREFIX_ID;
`else
                    state_d = PASS;
`endif
                end
            end
`ifdef UART_ARB_PREFIX_EN
            PREFIX_ID: begin
                cnt_d = '0;
                if (out_free) begin
                    load_en  = 1'b1;
                    load_dat = DATA_WIDTH'(AsciiZero) + DATA_WIDTH'(gidx_q);
                    state_d  = PREFIX_SEP;
                end
            end
            PREFIX_SEP: begin
                cnt_d = '0;
                if (out_free) begin
                    load_en  = 1'b1;
                    load_dat = DATA_WIDTH'(AsciiColon);
                    state_d  = PASS;
                end
            end
`endif
            PASS: begin
                if (req_acc) begin
                    load_en  = 1'b1;
                    load_dat = sel_dat;
                    cnt_d    = '0;
                    if (sel_last) begin
                        state_d = IDLE;
                        ptr_d   = ptr_next;
                    end
                end else if (!sel_vld && TO_EN) begin
                    // The owner has gone quiet; release the lock after TIMEOUT_CYCLES idle cycles
                    if (cnt_q == TO_LAST) begin
                        state_d = IDLE;
                        ptr_d   = ptr_next;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            gidx_q  <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Single-entry output stage: a loaded byte is held until uart_tx accepts it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tx_vld_q <= 1'b0;
            tx_dat_q <= '0;
        end else if (load_en) begin
            tx_vld_q <= 1'b1;
            tx_dat_q <= load_dat;
        end else if (i_tx_ready) begin
            tx_vld_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus randomized message sets checked against a round-robin message model.
// Latency: n/a.
// Backpressure: i_tx_ready is driven randomly or held low to stall the output.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TO   = 16;
`ifdef UART_ARB_PREFIX_EN
    localparam int PFX  = 2;
`else
    localparam int PFX  = 0;
`endif

    logic              i_clk;
    logic              i_rst;
    logic [NREQ*DW-1:0] i_req_data;
    logic [NREQ-1:0]   i_req_valid;
    logic [NREQ-1:0]   i_req_last;
    logic [NREQ-1:0]   o_req_ready;
    logic [NREQ-1:0]   o_grant;
    logic [DW-1:0]     o_tx_data;
    logic              o_tx_valid;
    logic              i_tx_ready;

    uart_tx_arbiter #(
        .NUM_REQ        (NREQ),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req_data  (i_req_data),
        .i_req_valid (i_req_valid),
        .i_req_last  (i_req_last),
        .o_req_ready (o_req_ready),
        .o_grant     (o_grant),
        .o_tx_data   (o_tx_data),
        .o_tx_valid  (o_tx_valid),
        .i_tx_ready  (i_tx_ready)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Per-requester byte queues: {last, data}
    logic [8:0] rbuf [NREQ][64];
    int         rhead [NREQ];
    int         rtail [NREQ];
    bit         in_msg [NREQ];
    int         run_len [NREQ];
    logic [NREQ-1:0] acc;
    int         rdy_pct;
    int         gap_pct;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    logic [NREQ-1:0] exp_own[$];
    logic [NREQ-1:0] glog[$];
    logic [NREQ-1:0] prev_g;
    int         n_tests;
    int         n_fail;

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic push_byte(input int k, input logic [7:0] d, input logic last);
        rbuf[k][rtail[k]] = {last, d};
        rtail[k]++;
    endtask

    // Drive each requester from its queue. Gaps are only inserted inside a message and are kept far below the timeout.
    task automatic drive();
        for (int k = 0; k < NREQ; k++) begin
            if (rhead[k] < rtail[k]) begin
                if (in_msg[k] && gap_pct > 0 && run_len[k] < 6 && $urandom_range(99) < gap_pct) begin
                    i_req_valid[k] = 1'b0;
                    run_len[k]++;
                end else begin
                    i_req_valid[k] = 1'b1;
                    run_len[k] = 0;
                end
                i_req_data[k*DW +: DW] = rbuf[k][rhead[k]][7:0];
                i_req_last[k]          = rbuf[k][rhead[k]][8];
            end else begin
                i_req_valid[k]         = 1'b0;
                i_req_data[k*DW +: DW] = '0;
                i_req_last[k]          = 1'b0;
            end
        end
        i_tx_ready = ($urandom_range(99) < rdy_pct);
    endtask

    // One clock: sample the handshakes mid-cycle, then update the queues and drive just after the edge
    task automatic cycle();
        @(negedge i_clk);
        acc = i_req_valid & o_req_ready;
        if (o_tx_valid && i_tx_ready) obs_q.push_back(o_tx_data);
        if (o_grant != '0 && prev_g == '0) glog.push_back(o_grant);
        prev_g = o_grant;
        if (|o_req_ready) chk_eq("ready_only_granted", o_req_ready & ~o_grant, 0);
        @(posedge i_clk);
        #1;
        for (int k = 0; k < NREQ; k++) begin
            if (acc[k]) begin
                in_msg[k] = !rbuf[k][rhead[k]][8];
                rhead[k]++;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        #1;
        chk_eq("rst_tx_valid", o_tx_valid, 0);
        chk_eq("rst_tx_data", o_tx_data, 0);
        chk_eq("rst_grant", o_grant, 0);
        chk_eq("rst_req_ready", o_req_ready, 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            rhead[k] = 0; rtail[k] = 0; in_msg[k] = 0; run_len[k] = 0;
        end
        prev_g = '0;
        obs_q.delete(); glog.delete(); exp_q.delete(); exp_own.delete();
        drive();
    endtask

    // Message-level reference: after reset the pointer is 0. Whole messages are granted in circular order from the pointer, and each completed message moves the pointer to the owner+1.
    task automatic build_expect();
        int p;
        int pos [NREQ];
        int k;
        bit found;
        p = 0;
        for (int j = 0; j < NREQ; j++) pos[j] = rhead[j];
        exp_q.delete(); exp_own.delete(); obs_q.delete(); glog.delete();
        forever begin
            found = 0;
            k = 0;
            for (int i = 0; i < NREQ; i++) begin
                if (!found && pos[(p + i) % NREQ] < rtail[(p + i) % NREQ]) begin
                    k = (p + i) % NREQ;
                    found = 1;
                end
            end
            if (!found) break;
            exp_own.push_back(NREQ'(1) << k);
            if (PFX != 0) begin
                exp_q.push_back(8'h30 + 8'(k));
                exp_q.push_back(8'h3A);
            end
            while (pos[k] < rtail[k]) begin
                exp_q.push_back(rbuf[k][pos[k]][7:0]);
                pos[k]++;
                if (rbuf[k][pos[k]-1][8]) break;
            end
            p = (k + 1) % NREQ;
        end
    endtask

    task automatic drain_check(input string tag);
        int  n;
        bit  done;
        n = 0;
        done = 0;
        while (!done && n < 3000) begin
            done = !o_tx_valid && (o_grant == '0);
            for (int k = 0; k < NREQ; k++) if (rhead[k] < rtail[k]) done = 0;
            if (!done) begin
                cycle();
                n++;
            end
        end
        chk_eq({tag, "_drained"}, done, 1);
        chk_eq({tag, "_nbytes"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk_eq($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
        chk_eq({tag, "_ngrants"}, glog.size(), exp_own.size());
        for (int i = 0; i < glog.size() && i < exp_own.size(); i++)
            chk_eq($sformatf("%s_grant%0d", tag, i), glog[i], exp_own[i]);
    endtask

    initial begin
        int n;
        logic [7:0] hold;
        n_tests = 0;
        n_fail  = 0;
        rdy_pct = 100;
        gap_pct = 0;
        i_req_valid = '0; i_req_last = '0; i_req_data = '0; i_tx_ready = 1'b0;
        do_reset();

        // Req0 sends A,B,LF with uart_tx always ready
        push_byte(0, 8'h41, 0); push_byte(0, 8'h42, 0); push_byte(0, 8'h0A, 1);
        drive();
        cycle();
        chk_eq("t1_grant", o_grant, 4'b0001);
        chk_eq("t1_ready", o_req_ready, (PFX == 0) ? 4'b0001 : 4'b0000);
        repeat (1 + PFX) cycle();
        chk_eq("t1_b0_vld", o_tx_valid, 1);
        chk_eq("t1_b0", o_tx_data, 8'h41);
        cycle();
        chk_eq("t1_b1", o_tx_data, 8'h42);
        cycle();
        chk_eq("t1_b2", o_tx_data, 8'h0A);
        chk_eq("t1_grant_clear", o_grant, 0);
        cycle();
        chk_eq("t1_tx_idle", o_tx_valid, 0);

        // Req1 and req2 request together: req1 finishes its whole message first
        do_reset();
        for (int i = 0; i < 3; i++) begin
            push_byte(1, 8'hA0 + 8'(i), i == 2);
            push_byte(2, 8'hB0 + 8'(i), i == 2);
        end
        build_expect();
        drive();
        drain_check("t2");

        // All four requesters send back-to-back 1-byte messages
        do_reset();
        for (int m = 0; m < 2; m++)
            for (int k = 0; k < NREQ; k++) push_byte(k, 8'(16 * k + m), 1);
        build_expect();
        drive();
        drain_check("t3");

        // Stall uart_tx for 5 cycles while the output stage holds a byte
        do_reset();
        for (int i = 0; i < 4; i++) push_byte(1, 8'h61 + 8'(i), i == 3);
        build_expect();
        drive();
        n = 0;
        while (!(o_tx_valid && o_tx_data == 8'h61) && n < 20) begin
            cycle();
            n++;
        end
        chk_eq("t4_first_loaded", o_tx_data, 8'h61);
        rdy_pct = 0;
        drive();
        hold = o_tx_data;
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk_eq("t4_stall_data", o_tx_data, hold);
            chk_eq("t4_stall_vld", o_tx_valid, 1);
            chk_eq("t4_stall_ready", o_req_ready, 0);
        end
        rdy_pct = 100;
        drive();
        drain_check("t4");

        // Req3 goes silent mid-message; after 16 idle cycles the lock drops and req0 is served
        do_reset();
        push_byte(3, 8'h77, 0);
        drive();
        n = 0;
        while (rhead[3] < rtail[3] && n < 20) begin
            cycle();
            n++;
        end
        chk_eq("t5_req3_taken", rhead[3], 1);
        push_byte(0, 8'h10, 1);
        drive();
        n = 0;
        while (o_grant == 4'b1000 && n < 40) begin
            cycle();
            n++;
        end
        chk_eq("t5_idle_cycles", n, TO);
        chk_eq("t5_released", o_grant, 0);
        cycle();
        chk_eq("t5_req0_grant", o_grant, 4'b0001);

        // Randomized message sets with random tx backpressure and gaps inside messages
        for (int r = 0; r < 8; r++) begin
            do_reset();
            for (int k = 0; k < NREQ; k++) begin
                int nm;
                nm = $urandom_range(0, 3);
                for (int m = 0; m < nm; m++) begin
                    int len;
                    len = $urandom_range(1, 5);
                    for (int b = 0; b < len; b++) push_byte(k, 8'($urandom), b == len - 1);
                end
            end
            rdy_pct = $urandom_range(40, 100);
            gap_pct = 25;
            build_expect();
            drive();
            drain_check($sformatf("rnd%0d", r));
        end
        rdy_pct = 100;
        gap_pct = 0;

        // Async reset in the middle of a message clears the output and grant at once
        do_reset();
        for (int i = 0; i < 5; i++) push_byte(0, 8'hC0 + 8'(i), i == 4);
        drive();
        repeat (3 + PFX) cycle();
        chk_eq("t6_busy", o_tx_valid, 1);
        chk_eq("t6_busy_grant", o_grant, 4'b0001);
        do_reset();
        cycle();
        chk_eq("t6_post_idle", o_tx_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
